bp_table_ctrl: RTL and testbench

Sequencer for the branch-predictor tables (PHT and BTB). It owns both table write ports and merges two write sources:
- the branch unit's PHT/BTB write buses;
- its own initialization sweep, which clears every entry after reset and on a global invalidate request.

It sits between the branch unit and the PHT/BTB storage. It also tells fetch when predictions may be used.

---
 rtl/bp_table_ctrl.sv | 149 ++++++++++++++
 tb/tb_bp_table_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bp_table_ctrl.sv
// Write-port sequencer for the PHT/BTB: clears both tables after reset or invalidate,
// then passes branch-unit updates through with one cycle of latency.
module bp_table_ctrl #(
    parameter int                  PHT_IDX_W = 10,
    parameter int                  PHT_ST_W  = 2,
    parameter logic [PHT_ST_W-1:0] PHT_INIT  = 2'b01,
    parameter int                  BTB_IDX_W = 7,
    parameter int                  BTB_TAG_W = 22,
    parameter int                  CNT_W     = 16
) (
    input  logic                                    clk,
    input  logic                                    resetn,
    input  logic [PHT_IDX_W+PHT_ST_W:0]             pht_wbus_i,
    input  logic [BTB_IDX_W+BTB_TAG_W+33:0]         btb_wbus_i,
    input  logic                                    inv_req_i,
    output logic                                    pht_we_o,
    output logic [PHT_IDX_W-1:0]                    pht_waddr_o,
    output logic [PHT_ST_W-1:0]                     pht_wdata_o,
    output logic                                    btb_we_o,
    output logic [BTB_IDX_W-1:0]                    btb_waddr_o,
    output logic                                    btb_wvalid_o,
    output logic [BTB_TAG_W-1:0]                    btb_wtag_o,
    output logic [31:0]                             btb_wtarget_o,
    output logic                                    bp_ready_o,
    output logic                                    busy_o,
    output logic [CNT_W-1:0]                        drop_cnt_o
);

    typedef enum logic {SWEEP, RUN} state_t;

    localparam logic [PHT_IDX_W:0] BTB_N = (PHT_IDX_W+1)'(1) << BTB_IDX_W;

    state_t                 state, state_nxt;
    logic [PHT_IDX_W-1:0]   cnt, cnt_nxt;

    logic                   bu_pht_we, bu_btb_we, bu_btb_valid;
    logic [PHT_IDX_W-1:0]   bu_pht_idx;
    logic [PHT_ST_W-1:0]    bu_pht_st;
    logic [BTB_IDX_W-1:0]   bu_btb_idx;
    logic [BTB_TAG_W-1:0]   bu_btb_tag;
    logic [31:0]            bu_btb_target;

    assign {bu_pht_we, bu_pht_idx, bu_pht_st} = pht_wbus_i;
    assign {bu_btb_we, bu_btb_valid, bu_btb_idx, bu_btb_tag, bu_btb_target} = btb_wbus_i;

    logic                   pht_we_nxt, btb_we_nxt, btb_wvalid_nxt, ready_nxt, busy_nxt, drop;
    logic [PHT_IDX_W-1:0]   pht_waddr_nxt;
    logic [PHT_ST_W-1:0]    pht_wdata_nxt;
    logic [BTB_IDX_W-1:0]   btb_waddr_nxt;
    logic [BTB_TAG_W-1:0]   btb_wtag_nxt;
    logic [31:0]            btb_wtarget_nxt;
    logic [CNT_W-1:0]       drop_nxt;

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        pht_we_nxt      = 1'b0;
        pht_waddr_nxt   = pht_waddr_o;
        pht_wdata_nxt   = pht_wdata_o;
        btb_we_nxt      = 1'b0;
        btb_waddr_nxt   = btb_waddr_o;
        btb_wvalid_nxt  = btb_wvalid_o;
        btb_wtag_nxt    = btb_wtag_o;
        btb_wtarget_nxt = btb_wtarget_o;
        ready_nxt       = 1'b0;
        busy_nxt        = 1'b1;
        drop            = 1'b0;
        case (state)
            SWEEP: begin
                pht_we_nxt    = 1'b1;
                pht_waddr_nxt = cnt;
                pht_wdata_nxt = PHT_INIT;
                // BTB is smaller; it is only cleared during the low part of the sweep
                if ({1'b0, cnt} < BTB_N) begin
                    btb_we_nxt      = 1'b1;
                    btb_waddr_nxt   = cnt[BTB_IDX_W-1:0];
                    btb_wvalid_nxt  = 1'b0;
                    btb_wtag_nxt    = '0;
                    btb_wtarget_nxt = '0;
                end
                drop = bu_pht_we | bu_btb_we;
                if (inv_req_i) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == '1)
                        state_nxt = RUN;
                end
            end
            RUN: begin
                if (inv_req_i) begin
                    state_nxt = SWEEP;
                    cnt_nxt   = '0;
                    drop      = bu_pht_we | bu_btb_we;
                end else begin
                    ready_nxt = 1'b1;
                    busy_nxt  = 1'b0;
                    if (bu_pht_we) begin
                        pht_we_nxt    = 1'b1;
                        pht_waddr_nxt = bu_pht_idx;
                        pht_wdata_nxt = bu_pht_st;
                    end
                    if (bu_btb_we) begin
                        btb_we_nxt      = 1'b1;
                        btb_waddr_nxt   = bu_btb_idx;
                        btb_wvalid_nxt  = bu_btb_valid;
                        btb_wtag_nxt    = bu_btb_tag;
                        btb_wtarget_nxt = bu_btb_target;
                    end
                end
            end
            default: state_nxt = SWEEP;
        endcase
        drop_nxt = (drop && drop_cnt_o != '1) ? drop_cnt_o + 1'b1 : drop_cnt_o;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= SWEEP;
            cnt           <= '0;
            pht_we_o      <= 1'b0;
            pht_waddr_o   <= '0;
            pht_wdata_o   <= '0;
            btb_we_o      <= 1'b0;
            btb_waddr_o   <= '0;
            btb_wvalid_o  <= 1'b0;
            btb_wtag_o    <= '0;
            btb_wtarget_o <= '0;
            bp_ready_o    <= 1'b0;
            busy_o        <= 1'b1;
            drop_cnt_o    <= '0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            pht_we_o      <= pht_we_nxt;
            pht_waddr_o   <= pht_waddr_nxt;
            pht_wdata_o   <= pht_wdata_nxt;
            btb_we_o      <= btb_we_nxt;
            btb_waddr_o   <= btb_waddr_nxt;
            btb_wvalid_o  <= btb_wvalid_nxt;
            btb_wtag_o    <= btb_wtag_nxt;
            btb_wtarget_o <= btb_wtarget_nxt;
            bp_ready_o    <= ready_nxt;
            busy_o        <= busy_nxt;
            drop_cnt_o    <= drop_nxt;
        end
    end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl: expected table writes are queued as stimulus is
// applied and retired by a negedge monitor; timing and counters are checked directly.
module tb_bp_table_ctrl;

    logic        clk, resetn, inv_req;
    logic [12:0] pht_wbus;
    logic [62:0] btb_wbus;
    logic        pht_we_o, btb_we_o, btb_wvalid_o, bp_ready_o, busy_o;
    logic [9:0]  pht_waddr_o;
    logic [1:0]  pht_wdata_o;
    logic [6:0]  btb_waddr_o;
    logic [21:0] btb_wtag_o;
    logic [31:0] btb_wtarget_o;
    logic [15:0] drop_cnt_o;

    bp_table_ctrl dut (
        .clk(clk), .resetn(resetn), .pht_wbus_i(pht_wbus), .btb_wbus_i(btb_wbus),
        .inv_req_i(inv_req), .pht_we_o(pht_we_o), .pht_waddr_o(pht_waddr_o),
        .pht_wdata_o(pht_wdata_o), .btb_we_o(btb_we_o), .btb_waddr_o(btb_waddr_o),
        .btb_wvalid_o(btb_wvalid_o), .btb_wtag_o(btb_wtag_o), .btb_wtarget_o(btb_wtarget_o),
        .bp_ready_o(bp_ready_o), .busy_o(busy_o), .drop_cnt_o(drop_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;
    logic        mon_en = 1'b0;
    logic [11:0] pht_q[$];
    logic [61:0] btb_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic push_sweep(input int pht_last, input int btb_last);
        for (int i = 0; i <= pht_last; i++) pht_q.push_back({10'(i), 2'b01});
        for (int i = 0; i <= btb_last; i++) btb_q.push_back({1'b0, 7'(i), 22'h0, 32'h0});
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (pht_we_o === 1'b1) begin
                if (pht_q.size() == 0) chk("pht_spurious_we", 64'(pht_we_o), 64'd0);
                else chk("pht_write", 64'({pht_waddr_o, pht_wdata_o}), 64'(pht_q.pop_front()));
            end
            if (btb_we_o === 1'b1) begin
                if (btb_q.size() == 0) chk("btb_spurious_we", 64'(btb_we_o), 64'd0);
                else chk("btb_write", 64'({btb_wvalid_o, btb_waddr_o, btb_wtag_o, btb_wtarget_o}),
                         64'(btb_q.pop_front()));
            end
        end
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pht_we"}, 64'(pht_we_o), 64'd0);
        chk({tag, "_pht_addr"}, 64'({pht_waddr_o, pht_wdata_o}), 64'd0);
        chk({tag, "_btb_we"}, 64'(btb_we_o), 64'd0);
        chk({tag, "_btb_data"}, 64'({btb_waddr_o, btb_wvalid_o, btb_wtag_o, btb_wtarget_o}), 64'd0);
        chk({tag, "_ready"}, 64'(bp_ready_o), 64'd0);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        chk({tag, "_drop"}, 64'(drop_cnt_o), 64'd0);
    endtask

    int n, t0;

    initial begin
        resetn = 1'b0; inv_req = 1'b0; pht_wbus = '0; btb_wbus = '0;
        repeat (3) cyc();
        chk_reset_vals("reset");

        // Power-up sweep with three dropped branch-unit cycles
        push_sweep(1023, 127);
        mon_en = 1'b1;
        resetn = 1'b1;
        n = 0;
        while (n < 3000) begin
            pht_wbus = '0; btb_wbus = '0;
            if (n == 200) pht_wbus = {1'b1, 10'h3FF, 2'b10};
            if (n == 300) btb_wbus = {1'b1, 1'b1, 7'h05, 22'h1, 32'h10};
            if (n == 400) begin
                pht_wbus = {1'b1, 10'h001, 2'b11};
                btb_wbus = {1'b1, 1'b1, 7'h06, 22'h2, 32'h20};
            end
            cyc(); n++;
            if (n == 600) chk("busy_mid_sweep", 64'(busy_o), 64'd1);
            if (bp_ready_o) break;
        end
        pht_wbus = '0; btb_wbus = '0;
        chk("ready_latency", 64'(n), 64'd1025);
        chk("drop_after_sweep", 64'(drop_cnt_o), 64'd3);
        chk("busy_run", 64'(busy_o), 64'd0);
        chk("sweep_pht_left", 64'(pht_q.size()), 64'd0);
        chk("sweep_btb_left", 64'(btb_q.size()), 64'd0);

        // Single PHT pass-through, then hold
        pht_wbus = {1'b1, 10'h2A5, 2'b11};
        pht_q.push_back({10'h2A5, 2'b11});
        cyc(); pht_wbus = '0;
        chk("pt_pht_we", 64'(pht_we_o), 64'd1);
        cyc();
        chk("pt_pht_we_off", 64'(pht_we_o), 64'd0);
        chk("pt_pht_hold", 64'({pht_waddr_o, pht_wdata_o}), 64'({10'h2A5, 2'b11}));

        // Simultaneous PHT + BTB
        pht_wbus = {1'b1, 10'h155, 2'b10};
        btb_wbus = {1'b1, 1'b1, 7'h11, 22'h3ABCD, 32'h1C00_0040};
        pht_q.push_back({10'h155, 2'b10});
        btb_q.push_back({1'b1, 7'h11, 22'h3ABCD, 32'h1C00_0040});
        cyc(); pht_wbus = '0; btb_wbus = '0;
        chk("both_we", 64'({pht_we_o, btb_we_o}), 64'd3);
        cyc();
        chk("btb_we_off", 64'(btb_we_o), 64'd0);
        chk("btb_hold", 64'(btb_wtarget_o), 64'h1C00_0040);
        chk("drop_run_unchanged", 64'(drop_cnt_o), 64'd3);

        // Invalidate in RUN with a BTB write, then invalidate again at sweep address 500
        push_sweep(500, 127);
        push_sweep(1023, 127);
        btb_wbus = {1'b1, 1'b1, 7'h22, 22'h12345, 32'h0000_8000};
        inv_req = 1'b1;
        cyc(); inv_req = 1'b0; btb_wbus = '0;
        chk("inv_ready", 64'(bp_ready_o), 64'd0);
        chk("inv_busy", 64'(busy_o), 64'd1);
        chk("inv_btb_dropped", 64'(btb_we_o), 64'd0);
        chk("inv_drop_cnt", 64'(drop_cnt_o), 64'd4);
        n = 1; t0 = -1;
        while (n < 4000 && !bp_ready_o) begin
            if (t0 < 0 && pht_we_o && pht_waddr_o == 10'd499) begin
                inv_req = 1'b1;
                t0 = n;
            end
            cyc(); inv_req = 1'b0; n++;
        end
        chk("resweep_start", 64'(t0), 64'd501);
        chk("restart_ready_latency", 64'(n - t0), 64'd1026);
        chk("restart_drop", 64'(drop_cnt_o), 64'd4);
        chk("restart_pht_left", 64'(pht_q.size()), 64'd0);
        chk("restart_btb_left", 64'(btb_q.size()), 64'd0);

        // Asynchronous reset in the middle of a sweep
        mon_en = 1'b0;
        inv_req = 1'b1;
        cyc(); inv_req = 1'b0;
        repeat (50) cyc();
        chk("pre_reset_sweeping", 64'(pht_we_o), 64'd1);
        pht_q.delete(); btb_q.delete();
        #2 resetn = 1'b0;
        #1 chk_reset_vals("async_reset");
        cyc();
        push_sweep(1023, 127);
        mon_en = 1'b1;
        resetn = 1'b1;
        n = 0;
        while (n < 3000 && !bp_ready_o) begin
            cyc(); n++;
        end
        chk("post_reset_ready_latency", 64'(n), 64'd1025);
        chk("post_reset_pht_left", 64'(pht_q.size()), 64'd0);
        chk("post_reset_btb_left", 64'(btb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
